// File: rtl/dense_drv_pkg.sv
// Shared definitions for the dense-layer driver: FSM states, Q8.8 format
// constants shared with the dense layer, and index-width helpers.
package dense_drv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } drv_state_e;

    localparam int unsigned Q_WIDTH = 16;
    localparam int unsigned Q_FRAC  = 8;

    // Width needed to hold indices 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_out_buffer.sv
// OUT_SIZE x DATA_WIDTH result register file with a per-entry valid mask.
// Entries that were never written read back as zero.
module dense_out_buffer
    import dense_drv_pkg::*;
#(
    parameter  int unsigned OUT_SIZE   = 3,
    parameter  int unsigned DATA_WIDTH = Q_WIDTH,
    localparam int unsigned IW         = idx_w(OUT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [IW-1:0]         wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  clr_i,
    input  logic [IW-1:0]         rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o
);

    logic [DATA_WIDTH-1:0] mem_q [OUT_SIZE];
    logic [OUT_SIZE-1:0]   mask_q;
    logic [OUT_SIZE-1:0]   wr_onehot;

    always_comb begin
        wr_onehot = '0;
        if (wr_en_i) wr_onehot[wr_idx_i] = 1'b1;
    end

    // Full includes a write landing this cycle, so a result strobe that
    // coincides with layer_done still counts towards completeness.
    assign full_o    = &(mask_q | wr_onehot);
    assign rd_data_o = mask_q[rd_idx_i] ? mem_q[rd_idx_i] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            for (int unsigned i = 0; i < OUT_SIZE; i++) mem_q[i] <= '0;
        end else begin
            if (clr_i)        mask_q <= '0;
            else if (wr_en_i) mask_q <= mask_q | wr_onehot;
            if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dense_layer_driver.sv
// Initiator/collector for one sequential dense layer: streams an input vector
// into the layer, gathers indexed results, and streams the result vector out.
module dense_layer_driver
    import dense_drv_pkg::*;
#(
    parameter  int unsigned IN_SIZE        = 9,
    parameter  int unsigned OUT_SIZE       = 3,
    parameter  int unsigned DATA_WIDTH     = Q_WIDTH,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned IDX_W          = idx_w(OUT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  layer_start,
    output logic [DATA_WIDTH-1:0] layer_data_in,
    output logic                  layer_data_valid,
    input  logic [DATA_WIDTH-1:0] layer_data_out,
    input  logic                  layer_data_out_valid,
    input  logic [IDX_W-1:0]      layer_out_idx,
    input  logic                  layer_done,
    input  logic                  layer_busy,
    input  logic                  err_clr,
    output logic                  err_framing,
    output logic                  err_index,
    output logic                  err_timeout
);

    localparam int unsigned CW = idx_w(IN_SIZE);
    localparam int unsigned TW = idx_w(TIMEOUT_CYCLES);

    localparam logic [CW-1:0]  IN_LAST = CW'(IN_SIZE - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(OUT_SIZE - 1);
    localparam logic [IDX_W:0] OUT_LIM = (IDX_W + 1)'(OUT_SIZE);

    drv_state_e       state_q, state_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             start_q, start_d;
    logic             err_framing_q, err_index_q, err_timeout_q;
    logic             frm_set, idx_set, tmo_set;
    logic             buf_clr, buf_wr, buf_full, idx_ok;
    logic [DATA_WIDTH-1:0] buf_rd_data;

    assign idx_ok = ({1'b0, layer_out_idx} < OUT_LIM);
    assign buf_wr = (state_q == WAIT) && layer_data_out_valid && idx_ok;

    dense_out_buffer #(
        .OUT_SIZE   (OUT_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (buf_wr),
        .wr_idx_i  (layer_out_idx),
        .wr_data_i (layer_data_out),
        .clr_i     (buf_clr),
        .rd_idx_i  (rd_idx_q),
        .rd_data_o (buf_rd_data),
        .full_o    (buf_full)
    );

    always_comb begin
        state_d          = state_q;
        in_cnt_d         = in_cnt_q;
        tmo_d            = tmo_q;
        rd_idx_d         = rd_idx_q;
        start_d          = 1'b0;
        frm_set          = 1'b0;
        idx_set          = 1'b0;
        tmo_set          = 1'b0;
        buf_clr          = 1'b0;
        s_ready          = 1'b0;
        m_valid          = 1'b0;
        layer_data_in    = '0;
        layer_data_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid && !layer_busy) begin
                    start_d = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                in_cnt_d = '0;
                state_d  = FEED;
            end
            FEED: begin
                s_ready          = 1'b1;
                layer_data_in    = s_data;
                layer_data_valid = s_valid;
                if (s_valid) begin
                    if (in_cnt_q == IN_LAST) begin
                        frm_set  = !s_last;
                        in_cnt_d = '0;
                        tmo_d    = '0;
                        state_d  = WAIT;
                    end else begin
                        frm_set  = s_last;
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (layer_data_out_valid && !idx_ok) idx_set = 1'b1;
                if (layer_done) begin
                    if (!buf_full) idx_set = 1'b1;
                    rd_idx_d = '0;
                    state_d  = DRAIN;
                end else if (tmo_q == TO_LAST) begin
                    tmo_set = 1'b1;
                    buf_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (rd_idx_q == RD_LAST) begin
                        buf_clr  = 1'b1;
                        rd_idx_d = '0;
                        state_d  = IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_data      = m_valid ? buf_rd_data : '0;
    assign m_last      = m_valid && (rd_idx_q == RD_LAST);
    assign layer_start = start_q;
    assign err_framing = err_framing_q;
    assign err_index   = err_index_q;
    assign err_timeout = err_timeout_q;

    // A same-cycle error set overrides err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_cnt_q      <= '0;
            tmo_q         <= '0;
            rd_idx_q      <= '0;
            start_q       <= 1'b0;
            err_framing_q <= 1'b0;
            err_index_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_cnt_q      <= in_cnt_d;
            tmo_q         <= tmo_d;
            rd_idx_q      <= rd_idx_d;
            start_q       <= start_d;
            err_framing_q <= (err_framing_q & ~err_clr) | frm_set;
            err_index_q   <= (err_index_q & ~err_clr) | idx_set;
            err_timeout_q <= (err_timeout_q & ~err_clr) | tmo_set;
        end
    end

endmodule
